// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, stall-vector bit positions,
// the bubble opcode and the EX->MEM payload layout used by the stage registers.
package pipe_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned ALUOP_W = 8;
    localparam int unsigned STALL_W = 6;

    // Bit positions in the global stall vector, one per pipeline stage.
    localparam int unsigned STALL_IF  = 0;
    localparam int unsigned STALL_ID  = 1;
    localparam int unsigned STALL_IS  = 2;
    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;
    localparam int unsigned STALL_WB  = 5;

    localparam logic [ALUOP_W-1:0] ALU_NOP = '0;

    // EX->MEM payload at the default widths, shared with sibling stage registers.
    typedef struct packed {
        logic               valid;
        logic [RADDR_W-1:0] reg_waddr;
        logic               we;
        logic [DATA_W-1:0]  reg_wdata;
        logic [ADDR_W-1:0]  mem_addr;
        logic [ALUOP_W-1:0] aluop;
        logic [DATA_W-1:0]  rt_data;
        logic [DATA_W-1:0]  pc;
    } ex_mem_t;

    // What a stage register does on a clock edge.
    typedef enum logic [1:0] {
        ACT_CAPTURE = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_HOLD    = 2'd2
    } stage_act_e;

    // Empty slot at the default widths.
    function automatic ex_mem_t bubble_payload();
        ex_mem_t p;
        p       = '0;
        p.aluop = ALU_NOP;
        return p;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for per-stage
// performance counters.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear has priority; increment stops at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ex_mem_gen.sv
// Parametrised EX/MEM pipeline register with flush, valid tracking,
// write-enable gating, pc field and an EX stall-cycle counter.
module pipe_ex_mem_gen #(
    parameter int unsigned        DATA_W  = pipe_pkg::DATA_W,
    parameter int unsigned        ADDR_W  = pipe_pkg::ADDR_W,
    parameter int unsigned        RADDR_W = pipe_pkg::RADDR_W,
    parameter int unsigned        ALUOP_W = pipe_pkg::ALUOP_W,
    parameter int unsigned        STALL_W = pipe_pkg::STALL_W,
    parameter int unsigned        SRC_IDX = pipe_pkg::STALL_EX,
    parameter int unsigned        DST_IDX = pipe_pkg::STALL_MEM,
    parameter int unsigned        CNT_W   = 16,
    parameter logic [ALUOP_W-1:0] ALU_NOP = pipe_pkg::ALU_NOP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               clr_cnt,
    input  logic               ex_valid,
    input  logic [RADDR_W-1:0] ex_reg_waddr,
    input  logic               ex_we,
    input  logic [DATA_W-1:0]  ex_reg_wdata,
    input  logic [ADDR_W-1:0]  ex_mem_addr,
    input  logic [ALUOP_W-1:0] ex_aluop,
    input  logic [DATA_W-1:0]  ex_rt_data,
    input  logic [DATA_W-1:0]  ex_pc,
    output logic               mem_valid,
    output logic [RADDR_W-1:0] mem_reg_waddr,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_reg_wdata,
    output logic [ADDR_W-1:0]  mem_mem_addr,
    output logic [ALUOP_W-1:0] mem_aluop,
    output logic [DATA_W-1:0]  mem_rt_data,
    output logic [DATA_W-1:0]  mem_pc,
    output logic [CNT_W-1:0]   stall_cycles
);

    import pipe_pkg::*;

    // Payload at this instance's widths.
    typedef struct packed {
        logic               valid;
        logic [RADDR_W-1:0] reg_waddr;
        logic               we;
        logic [DATA_W-1:0]  reg_wdata;
        logic [ADDR_W-1:0]  mem_addr;
        logic [ALUOP_W-1:0] aluop;
        logic [DATA_W-1:0]  rt_data;
        logic [DATA_W-1:0]  pc;
    } payload_t;

    localparam payload_t BUBBLE = '{aluop: ALU_NOP, default: '0};

    stage_act_e act;
    payload_t   q;
    payload_t   q_next;

    // Only the EX and MEM stall bits matter here.
    logic unused_stall_bits;
    assign unused_stall_bits = ^stall;

    // Pick the edge action: flush, then EX-held/MEM-moving bubble, then hold.
    // The illegal EX-running/MEM-held combination falls through to capture.
    always_comb begin
        act = ACT_CAPTURE;
        if (flush) begin
            act = ACT_BUBBLE;
        end else if (stall[SRC_IDX] && !stall[DST_IDX]) begin
            act = ACT_BUBBLE;
        end else if (stall[SRC_IDX]) begin
            act = ACT_HOLD;
        end
    end

    // Next payload; write enable is forced low for invalid slots.
    always_comb begin
        q_next = q;
        case (act)
            ACT_BUBBLE: q_next = BUBBLE;
            ACT_HOLD:   q_next = q;
            default: begin
                q_next.valid     = ex_valid;
                q_next.reg_waddr = ex_reg_waddr;
                q_next.we        = ex_we & ex_valid;
                q_next.reg_wdata = ex_reg_wdata;
                q_next.mem_addr  = ex_mem_addr;
                q_next.aluop     = ex_aluop;
                q_next.rt_data   = ex_rt_data;
                q_next.pc        = ex_pc;
            end
        endcase
    end

    // Payload register; reset loads an empty slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= BUBBLE;
        end else begin
            q <= q_next;
        end
    end

    assign mem_valid     = q.valid;
    assign mem_reg_waddr = q.reg_waddr;
    assign mem_we        = q.we;
    assign mem_reg_wdata = q.reg_wdata;
    assign mem_mem_addr  = q.mem_addr;
    assign mem_aluop     = q.aluop;
    assign mem_rt_data   = q.rt_data;
    assign mem_pc        = q.pc;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_cnt),
        .inc   (stall[SRC_IDX]),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_ex_mem_gen.sv
// Bench for pipe_ex_mem_gen: a default instance and a narrow-counter,
// non-zero-NOP instance share stimulus and are compared against a model.
module tb_pipe_ex_mem_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [5:0]  stall;
    logic        flush, clr_cnt, ex_valid, ex_we;
    logic [4:0]  ex_reg_waddr;
    logic [31:0] ex_reg_wdata, ex_mem_addr, ex_rt_data, ex_pc;
    logic [7:0]  ex_aluop;

    logic        mem_valid_a, mem_we_a, mem_valid_b, mem_we_b;
    logic [4:0]  mem_reg_waddr_a, mem_reg_waddr_b;
    logic [31:0] mem_reg_wdata_a, mem_mem_addr_a, mem_rt_data_a, mem_pc_a;
    logic [31:0] mem_reg_wdata_b, mem_mem_addr_b, mem_rt_data_b, mem_pc_b;
    logic [7:0]  mem_aluop_a, mem_aluop_b;
    logic [15:0] stall_cycles_a;
    logic [3:0]  stall_cycles_b;

    pipe_ex_mem_gen dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .ex_valid(ex_valid), .ex_reg_waddr(ex_reg_waddr), .ex_we(ex_we),
        .ex_reg_wdata(ex_reg_wdata), .ex_mem_addr(ex_mem_addr), .ex_aluop(ex_aluop),
        .ex_rt_data(ex_rt_data), .ex_pc(ex_pc),
        .mem_valid(mem_valid_a), .mem_reg_waddr(mem_reg_waddr_a), .mem_we(mem_we_a),
        .mem_reg_wdata(mem_reg_wdata_a), .mem_mem_addr(mem_mem_addr_a),
        .mem_aluop(mem_aluop_a), .mem_rt_data(mem_rt_data_a), .mem_pc(mem_pc_a),
        .stall_cycles(stall_cycles_a)
    );

    pipe_ex_mem_gen #(
        .CNT_W   (4),
        .ALU_NOP (8'hA5)
    ) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .ex_valid(ex_valid), .ex_reg_waddr(ex_reg_waddr), .ex_we(ex_we),
        .ex_reg_wdata(ex_reg_wdata), .ex_mem_addr(ex_mem_addr), .ex_aluop(ex_aluop),
        .ex_rt_data(ex_rt_data), .ex_pc(ex_pc),
        .mem_valid(mem_valid_b), .mem_reg_waddr(mem_reg_waddr_b), .mem_we(mem_we_b),
        .mem_reg_wdata(mem_reg_wdata_b), .mem_mem_addr(mem_mem_addr_b),
        .mem_aluop(mem_aluop_b), .mem_rt_data(mem_rt_data_b), .mem_pc(mem_pc_b),
        .stall_cycles(stall_cycles_b)
    );

    // The control unit never runs EX while holding MEM.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            assert (!(stall[3] == 1'b0 && stall[4] == 1'b1))
            else $error("illegal stall vector %b", stall);
        end
    end

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Expected contents of the MEM-side slot and counters.
    logic        e_valid, e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_addr, e_rt, e_pc;
    logic [7:0]  e_aluop_a, e_aluop_b;
    int unsigned e_cnt_a, e_cnt_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_empty_slot();
        e_valid   = 1'b0;
        e_we      = 1'b0;
        e_waddr   = '0;
        e_wdata   = '0;
        e_addr    = '0;
        e_rt      = '0;
        e_pc      = '0;
        e_aluop_a = 8'h00;
        e_aluop_b = 8'hA5;
    endtask

    task automatic model_reset();
        model_empty_slot();
        e_cnt_a = 0;
        e_cnt_b = 0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge();
        bit ex_stalled, mem_stalled;
        ex_stalled  = stall[3];
        mem_stalled = stall[4];
        if (flush) begin
            model_empty_slot();
        end else if (ex_stalled && !mem_stalled) begin
            model_empty_slot();
        end else if (!ex_stalled) begin
            e_valid   = ex_valid;
            e_we      = ex_we && ex_valid;
            e_waddr   = ex_reg_waddr;
            e_wdata   = ex_reg_wdata;
            e_addr    = ex_mem_addr;
            e_rt      = ex_rt_data;
            e_pc      = ex_pc;
            e_aluop_a = ex_aluop;
            e_aluop_b = ex_aluop;
        end
        if (clr_cnt) begin
            e_cnt_a = 0;
            e_cnt_b = 0;
        end else if (ex_stalled) begin
            if (e_cnt_a < 65535) e_cnt_a++;
            if (e_cnt_b < 15) e_cnt_b++;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid_a"}, mem_valid_a, e_valid);
        check({tag, ".we_a"},    mem_we_a, e_we);
        check({tag, ".waddr_a"}, mem_reg_waddr_a, e_waddr);
        check({tag, ".wdata_a"}, mem_reg_wdata_a, e_wdata);
        check({tag, ".addr_a"},  mem_mem_addr_a, e_addr);
        check({tag, ".aluop_a"}, mem_aluop_a, e_aluop_a);
        check({tag, ".rt_a"},    mem_rt_data_a, e_rt);
        check({tag, ".pc_a"},    mem_pc_a, e_pc);
        check({tag, ".cnt_a"},   stall_cycles_a, e_cnt_a[15:0]);
        check({tag, ".valid_b"}, mem_valid_b, e_valid);
        check({tag, ".we_b"},    mem_we_b, e_we);
        check({tag, ".waddr_b"}, mem_reg_waddr_b, e_waddr);
        check({tag, ".wdata_b"}, mem_reg_wdata_b, e_wdata);
        check({tag, ".aluop_b"}, mem_aluop_b, e_aluop_b);
        check({tag, ".pc_b"},    mem_pc_b, e_pc);
        check({tag, ".cnt_b"},   stall_cycles_b, e_cnt_b[3:0]);
        check({tag, ".we_implies_valid"}, mem_we_a & ~mem_valid_a, 1'b0);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic random_ex();
        ex_valid     = 1'($urandom);
        ex_we        = 1'($urandom);
        ex_reg_waddr = 5'($urandom);
        ex_reg_wdata = $urandom;
        ex_mem_addr  = $urandom;
        ex_aluop     = 8'($urandom);
        ex_rt_data   = $urandom;
        ex_pc        = $urandom;
    endtask

    // Legal stall vector: EX/MEM bits from the three allowed pairs, others random.
    function automatic logic [5:0] random_stall();
        logic [5:0] s;
        s = 6'($urandom);
        case ($urandom_range(0, 2))
            0:       begin s[3] = 1'b0; s[4] = 1'b0; end
            1:       begin s[3] = 1'b1; s[4] = 1'b0; end
            default: begin s[3] = 1'b1; s[4] = 1'b1; end
        endcase
        return s;
    endfunction

    initial begin
        rst = 1'b0; stall = '0; flush = 1'b0; clr_cnt = 1'b0;
        random_ex();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk) rst = 1'b1;

        // Reset in the middle of operation takes effect without an edge.
        ex_reg_wdata = 32'hDEADBEEF; ex_we = 1'b1; ex_valid = 1'b1; ex_aluop = 8'h5C;
        step("t1_load");
        check("t1_loaded", mem_reg_wdata_a, 32'hDEADBEEF);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("t1_async_wdata", mem_reg_wdata_a, 32'h0);
        check("t1_async_we", mem_we_a, 1'b0);
        check("t1_async_aluop_b", mem_aluop_b, 8'hA5);
        compare_all("t1_async");
        @(negedge clk) rst = 1'b1;

        // Capture, then an invalid slot with we asserted.
        random_ex();
        stall = 6'b000000; ex_valid = 1'b1; ex_we = 1'b1; ex_reg_waddr = 5'd7; ex_pc = 32'h100;
        step("t2_cap");
        check("t2_waddr", mem_reg_waddr_a, 5'd7);
        check("t2_we", mem_we_a, 1'b1);
        check("t2_pc", mem_pc_a, 32'h100);
        ex_valid = 1'b0;
        step("t2_inv");
        check("t2_inv_we", mem_we_a, 1'b0);
        check("t2_inv_valid", mem_valid_a, 1'b0);

        // Hold while both EX and MEM stall.
        random_ex(); ex_aluop = 8'h23; ex_valid = 1'b1;
        step("t3_cap");
        for (int unsigned i = 0; i < 3; i++) begin
            stall = 6'b011111;
            random_ex();
            step("t3_hold");
            check("t3_aluop", mem_aluop_a, 8'h23);
            check("t3_cnt", stall_cycles_a, 16'(i + 1));
        end

        // Bubble when EX holds and MEM moves, then capture of the held instruction.
        stall = 6'b001111;
        step("t4_bub");
        check("t4_valid", mem_valid_a, 1'b0);
        check("t4_aluop_b", mem_aluop_b, 8'hA5);
        check("t4_waddr", mem_reg_waddr_b, 5'd0);
        stall = 6'b000000;
        step("t4_recap");
        check("t4_recap_pc", mem_pc_a, ex_pc);

        // Flush beats hold but the counter still counts.
        random_ex(); ex_valid = 1'b1; ex_we = 1'b1;
        step("t5_cap");
        stall = 6'b011111; flush = 1'b1;
        step("t5_flush");
        check("t5_valid", mem_valid_a, 1'b0);
        check("t5_cnt", stall_cycles_a, 16'd5);
        flush = 1'b0;

        // Narrow counter saturates, then clear wins over increment.
        stall = 6'b001000;
        for (int unsigned i = 0; i < 20; i++) begin
            random_ex();
            step("t6_sat");
        end
        check("t6_sat_b", stall_cycles_b, 4'hF);
        clr_cnt = 1'b1;
        step("t6_clr");
        check("t6_clr_b", stall_cycles_b, 4'h0);
        check("t6_clr_a", stall_cycles_a, 16'h0);
        clr_cnt = 1'b0;

        // Randomised traffic.
        for (int unsigned i = 0; i < 400; i++) begin
            random_ex();
            stall   = random_stall();
            flush   = ($urandom_range(0, 7) == 0);
            clr_cnt = ($urandom_range(0, 31) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ex_mem_gen.md
Name: pipe_ex_mem_gen

Overview:
- Parametrised EX/MEM pipeline register. It is the successor to the fixed-width EX/MEM latch.
- Sits between the execute stage and the memory-access stage. Captures EX results each cycle under control of the global stall vector.
- Adds behaviour the fixed latch lacks: flush, a valid bit, write-enable gating on invalid slots, a pc field, and a saturating stall-cycle performance counter with synchronous clear.

Parameters:
- DATA_W, 32, width of reg_wdata, rt_data and pc.
- ADDR_W, 32, width of the memory address.
- RADDR_W, 5, register-file address width.
- ALUOP_W, 8, ALU opcode width.
- STALL_W, 6, width of the global stall vector.
- SRC_IDX, 3, stall-vector bit that stalls the EX stage.
- DST_IDX, 4, stall-vector bit that stalls the MEM stage. Must equal SRC_IDX+1.
- CNT_W, 16, width of the stall-cycle counter.
- ALU_NOP, 0, aluop value inserted for a bubble.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  STALL_W  global stall vector from the control unit
- flush  in  1  kill the in-flight instruction (exception/branch recovery)
- clr_cnt  in  1  synchronous clear of stall_cycles
- ex_valid  in  1  EX stage holds a real instruction
- ex_reg_waddr  in  RADDR_W  destination register
- ex_we  in  1  register write enable
- ex_reg_wdata  in  DATA_W  ALU result
- ex_mem_addr  in  ADDR_W  load/store effective address
- ex_aluop  in  ALUOP_W  opcode forwarded for load/store decode
- ex_rt_data  in  DATA_W  store data
- ex_pc  in  DATA_W  instruction pc
- mem_valid  out  1  registered valid
- mem_reg_waddr  out  RADDR_W  registered
- mem_we  out  1  registered, gated by valid
- mem_reg_wdata  out  DATA_W  registered
- mem_mem_addr  out  ADDR_W  registered
- mem_aluop  out  ALUOP_W  registered
- mem_rt_data  out  DATA_W  registered
- mem_pc  out  DATA_W  registered
- stall_cycles  out  CNT_W  saturating count of cycles with stall[SRC_IDX]=1

Behaviour:
- Reset (rst=0, asynchronous, immediate effect):
  - All mem_* outputs go to 0, mem_aluop to ALU_NOP, and stall_cycles to 0.
  - Release is synchronised externally. The block takes no special action on release.
- On each rising edge with rst=1, the payload registers are updated by the first matching case, in this priority order:
  1. flush=1 → BUBBLE, regardless of stall.
  2. stall[SRC_IDX]=1 and stall[DST_IDX]=0 → BUBBLE. EX is held, MEM proceeds, so a NOP is inserted.
  3. stall[SRC_IDX]=1 and stall[DST_IDX]=1 → HOLD. All mem_* keep their values.
  4. stall[SRC_IDX]=0 → CAPTURE:
     - mem_valid ← ex_valid.
     - mem_we ← ex_we & ex_valid.
     - All other fields are copied from ex_*.
- BUBBLE state: mem_valid=0, mem_we=0, mem_reg_waddr=0, mem_aluop=ALU_NOP, all data/addr/pc fields=0.
- stall[SRC_IDX]=0 with stall[DST_IDX]=1 is illegal from the control unit. The block treats it as CAPTURE; the bench flags it with an assertion.
- Latency: 1 cycle from ex_* to mem_* on CAPTURE. There is no combinational path from input to output.
- Invariant: mem_we=1 implies mem_valid=1, in all cases.
- stall_cycles, evaluated on each rising edge:
  - clr_cnt=1 → 0. Clear wins over increment in the same cycle.
  - else stall[SRC_IDX]=1 and count ≠ 2^CNT_W−1 → count+1.
  - else hold, so the counter saturates at all-ones and never wraps.
  - flush does not affect the counter.
- Stall bits other than SRC_IDX/DST_IDX are ignored.

Decomposition:
- Shared package (pipe_pkg):
  - Width constants: DATA_W, ADDR_W, RADDR_W, ALUOP_W, STALL_W.
  - Stall-index constants STALL_IF..STALL_WB (0..5).
  - ALU_NOP.
  - A packed struct/typedef for the EX→MEM payload, so sibling stage registers (pipe_id_ex_gen, pipe_mem_wb_gen) reuse it.
- One sub-module: sat_counter, parameter W, ports clk/rst/clr/inc/count. It is reused for the other per-stage performance counters.

Test Plan:
1. Reset mid-operation:
   - Stimulus: load ex_reg_wdata=32'hDEADBEEF, ex_we=1, ex_valid=1, clock once, then pull rst=0 between edges.
   - Required response: mem_reg_wdata=0, mem_we=0, mem_aluop=ALU_NOP immediately, without waiting for an edge.
2. Capture and invalid gating:
   - Stimulus: stall=0, ex_valid=1, ex_we=1, ex_reg_waddr=5'd7, ex_pc=32'h100, one edge.
   - Required response: mem_reg_waddr=7, mem_we=1, mem_pc=32'h100.
   - Then ex_valid=0 with ex_we=1 → mem_we=0, mem_valid=0.
3. Hold:
   - Stimulus: after a capture of aluop=8'h23, stall=6'b011111 for 3 cycles with ex_* changing each cycle.
   - Required response: mem_* unchanged; stall_cycles goes 0→3.
4. Bubble:
   - Stimulus: stall=6'b001111 for 1 edge.
   - Required response: mem_valid=0, mem_we=0, mem_aluop=ALU_NOP, mem_reg_waddr=0.
   - Next edge with stall=0 captures the held EX instruction.
5. Flush priority:
   - Stimulus: flush=1 with stall=6'b011111 and a valid payload present.
   - Required response: bubble on the next edge; stall_cycles still increments by 1.
6. Counter saturation and clear:
   - Stimulus: CNT_W=4, stall[3]=1 for 20 cycles.
   - Required response: stall_cycles=4'hF held.
   - Then clr_cnt=1 together with stall[3]=1 → 0.
